conv2d_stream_k: RTL

//  Parametrised single-channel 2-D convolution engine on a 16-bit AXI-Stream. Successor to the fixed 3x3 conv2D core.

---
 rtl/conv2d_stream_k.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/conv2d_stream_k.sv
// conv2d_stream_k: streaming KSIZE x KSIZE signed convolution over IMG_W x IMG_H frames (valid region only).
// Define CONV2D_RELU_EN to clamp negative saturated results to zero.
module conv2d_stream_k #(
   parameter int DATA_W     = 16,
   parameter int KSIZE      = 3,
   parameter int IMG_W      = 8,
   parameter int IMG_H      = 8,
   parameter int ACC_W      = 40,
   parameter int FRAC_SHIFT = 0
) (
   input  logic                AXIS_ACLK,
   input  logic                AXIS_ARESET,
   input  logic                WLOAD,
   input  logic [DATA_W-1:0]   S_AXIS_TDATA,
   input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
   input  logic                S_AXIS_TLAST,
   input  logic                S_AXIS_TVALID,
   output logic                S_AXIS_TREADY,
   output logic [DATA_W-1:0]   M_AXIS_TDATA,
   output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
   output logic                M_AXIS_TLAST,
   output logic                M_AXIS_TVALID,
   input  logic                M_AXIS_TREADY,
   output logic                ERR
);

   localparam int NW    = KSIZE * KSIZE;
   localparam int WC_W  = $clog2(NW + 1);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   localparam logic [WC_W-1:0]  NW_C     = WC_W'(NW);
   localparam logic [WC_W-1:0]  NW_M1    = WC_W'(NW - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] COL_K1   = COL_W'(KSIZE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(KSIZE - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic {S_LOAD, S_RUN} state_t;
   state_t state, state_nxt;

   logic [WC_W-1:0]   wcnt;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              wload_pend;
   logic              err;
   logic              m_valid;
   logic              m_last;
   logic [DATA_W-1:0] m_data;

   logic signed [DATA_W-1:0] w       [NW];
   logic signed [DATA_W-1:0] lb      [KSIZE-1][IMG_W];
   logic signed [DATA_W-1:0] win     [KSIZE][KSIZE];
   logic signed [DATA_W-1:0] win_nxt [KSIZE][KSIZE];

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sh;
   logic [DATA_W-1:0]       res;
   logic s_fire, at_zero, go_load, last_px, in_window, produce;
   logic unused_keep;

   assign unused_keep = ^S_AXIS_TKEEP;
   assign at_zero     = (row == '0) && (col == '0);
   assign last_px     = (row == ROW_LAST) && (col == COL_LAST);
   assign in_window   = (row >= ROW_K1) && (col >= COL_K1);
   assign go_load     = (state == S_RUN) && (WLOAD || wload_pend) && at_zero;
   assign s_fire      = S_AXIS_TVALID && S_AXIS_TREADY;
   assign produce     = (state == S_RUN) && s_fire && in_window;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt     = state;
      S_AXIS_TREADY = 1'b0;
      if (!AXIS_ARESET) begin
         case (state)
            S_LOAD: begin
               S_AXIS_TREADY = 1'b1;
               if (S_AXIS_TVALID && S_AXIS_TLAST) state_nxt = S_RUN;
            end
            S_RUN: begin
               // Pixels are taken only when the output register can absorb a result.
               S_AXIS_TREADY = (!m_valid || M_AXIS_TREADY) && !go_load;
               if (go_load) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
         endcase
      end
   end

   // Window after the incoming pixel shifts in: oldest row at index 0, newest column at KSIZE-1.
   always_comb begin
      for (int i = 0; i < KSIZE; i++) begin
         for (int j = 0; j < KSIZE - 1; j++) begin
            win_nxt[i][j] = win[i][j+1];
         end
      end
      for (int i = 0; i < KSIZE - 1; i++) begin
         win_nxt[i][KSIZE-1] = lb[i][col];
      end
      win_nxt[KSIZE-1][KSIZE-1] = S_AXIS_TDATA;
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < KSIZE; i++) begin
         for (int j = 0; j < KSIZE; j++) begin
            acc = acc + ACC_W'(w[i*KSIZE+j]) * ACC_W'(win_nxt[i][j]);
         end
      end
      acc_sh = acc >>> FRAC_SHIFT;
      if (acc_sh > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
      else if (acc_sh < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
      else                       res = acc_sh[DATA_W-1:0];
`ifdef CONV2D_RELU_EN
      if (res[DATA_W-1]) res = '0;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge AXIS_ACLK) begin
      if (AXIS_ARESET) begin
         state      <= S_LOAD;
         wcnt       <= '0;
         col        <= '0;
         row        <= '0;
         wload_pend <= 1'b0;
         err        <= 1'b0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         m_data     <= '0;
         // NOTE: weights and line buffers are reset because a short weight packet must leave zeros behind.
         for (int n = 0; n < NW; n++) w[n] <= '0;
         for (int i = 0; i < KSIZE - 1; i++)
            for (int c = 0; c < IMG_W; c++) lb[i][c] <= '0;
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++) win[i][j] <= '0;
      end else begin
         state <= state_nxt;

         if (produce) begin
            m_valid <= 1'b1;
            m_data  <= res;
            m_last  <= last_px;
         end else if (M_AXIS_TREADY) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end

         case (state)
            S_LOAD: begin
               if (s_fire) begin
                  if (wcnt < NW_C) begin
                     for (int n = 0; n < NW; n++)
                        if (wcnt == WC_W'(n)) w[n] <= S_AXIS_TDATA;
                     wcnt <= wcnt + 1'b1;
                  end
                  if (S_AXIS_TLAST) begin
                     if (wcnt < NW_M1) err <= 1'b1;
                     wcnt <= '0;
                     col  <= '0;
                     row  <= '0;
                  end
               end
            end
            S_RUN: begin
               if (go_load) begin
                  wload_pend <= 1'b0;
                  wcnt       <= '0;
                  for (int n = 0; n < NW; n++) w[n] <= '0;
               end else if (WLOAD) begin
                  wload_pend <= 1'b1;
               end
               if (s_fire) begin
                  win <= win_nxt;
                  for (int c = 0; c < IMG_W; c++) begin
                     if (col == COL_W'(c)) begin
                        for (int i = 0; i < KSIZE - 2; i++) lb[i][c] <= lb[i+1][c];
                        lb[KSIZE-2][c] <= S_AXIS_TDATA;
                     end
                  end
                  if (last_px != S_AXIS_TLAST) err <= 1'b1;
                  if (last_px || S_AXIS_TLAST) begin
                     col <= '0;
                     row <= '0;
                  end else if (col == COL_LAST) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign M_AXIS_TVALID = m_valid;
   assign M_AXIS_TDATA  = m_data;
   assign M_AXIS_TLAST  = m_last;
   assign M_AXIS_TKEEP  = {(DATA_W/8){m_valid}};
   assign ERR           = err;

endmodule
